mul_div_unit: RTL and testbench

//  Iterative multiply/divide unit with architectural HI/LO registers, placed

---
 rtl/mul_div_unit.sv | 135 +++++++++++++
 tb/tb_mul_div_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO (MULTU/MULT/DIVU/DIV, MTHI/MTLO).
// Define MULDIV_SIGNED_EN to honour op[0] as signed; otherwise every op is unsigned.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] Adat,
  input  logic [WIDTH-1:0] Bdat,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] Wdat,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [1:0]       dbg_state
);

  // Handshake: start is accepted only while busy=0; once accepted, busy stays
  // high WIDTH+1 cycles and done pulses for the single cycle after busy drops.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2} state_t;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] p_hi, p_lo, opb, hi_r, lo_r;
  logic             is_div, neg_q, neg_r, div0, done_r;
  logic             signed_op, sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH+1:0] div_diff;
  logic             div_ok;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic             unused_bits;

`ifdef MULDIV_SIGNED_EN
  assign signed_op   = op[0];
  assign unused_bits = div_diff[WIDTH];
`else
  assign signed_op   = 1'b0;
  assign unused_bits = ^{div_diff[WIDTH], op[0]};
`endif

  assign sa    = signed_op & Adat[WIDTH-1];
  assign sb    = signed_op & Bdat[WIDTH-1];
  assign mag_a = sa ? -Adat : Adat;
  assign mag_b = sb ? -Bdat : Bdat;

  // One iteration of shift-add multiply and of restoring divide.
  assign mul_sum  = {1'b0, p_hi} + (p_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
  assign div_diff = {1'b0, p_hi, p_lo[WIDTH-1]} - {2'b00, opb};
  assign div_ok   = ~div_diff[WIDTH+1];

  // Divide-by-zero leaves rem=|A| and quotient all ones; only LO needs forcing.
  assign prod_fix = neg_q ? -{p_hi, p_lo} : {p_hi, p_lo};
  assign quo_fix  = div0 ? {WIDTH{1'b1}} : (neg_q ? -p_lo : p_lo);
  assign rem_fix  = neg_r ? -p_hi : p_hi;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_CALC;
      S_CALC:  if (cnt == CW'(WIDTH-1)) state_nx = S_FIX;
      S_FIX:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
      opb    <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nx;
      done_r <= (state == S_FIX);
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt    <= '0;
            is_div <= op[1];
            neg_q  <= sa ^ sb;
            neg_r  <= op[1] & sa;
            div0   <= op[1] & (Bdat == '0);
            p_hi   <= '0;
            // Multiply: opb=multiplicand, p_lo=multiplier. Divide: opb=divisor, p_lo=dividend.
            opb    <= op[1] ? mag_b : mag_a;
            p_lo   <= op[1] ? mag_a : mag_b;
          end else begin
            if (hi_we) hi_r <= Wdat;
            if (lo_we) lo_r <= Wdat;
          end
        end
        S_CALC: begin
          cnt <= cnt + CW'(1);
          if (is_div) begin
            p_hi <= div_ok ? div_diff[WIDTH-1:0] : {p_hi[WIDTH-2:0], p_lo[WIDTH-1]};
            p_lo <= {p_lo[WIDTH-2:0], div_ok};
          end else begin
            {p_hi, p_lo} <= {mul_sum, p_lo[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          if (is_div) begin
            hi_r <= rem_fix;
            lo_r <= quo_fix;
          end else begin
            {hi_r, lo_r} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = done_r;
  assign HI        = hi_r;
  assign LO        = lo_r;
  assign dbg_state = state;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit (WIDTH=32): latency, arithmetic, MTHI/MTLO, abort.
module tb_mul_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] Adat, Bdat, Wdat;
  logic         busy, done;
  logic [W-1:0] HI, LO;
  logic [1:0]   dbg_state;

  int total = 0;
  int bad   = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .Adat(Adat), .Bdat(Bdat),
    .hi_we(hi_we), .lo_we(lo_we), .Wdat(Wdat), .busy(busy), .done(done),
    .HI(HI), .LO(LO), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Driver: launch one op, scramble operands while busy, return edges-to-done and busy cycles.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output int busy_n);
    @(negedge clk);
    start = 1'b1; op = o; Adat = a; Bdat = b;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    lat = 1; busy_n = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_n++;
      Adat = $urandom; Bdat = $urandom; op = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op = 2'b00; Adat = '0; Bdat = '0;
    hi_we = 1'b0; lo_we = 1'b0; Wdat = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (HI !== '0) begin bad++; $display("FAIL reset_hi: got %h want 0", HI); end
    total++; if (LO !== '0) begin bad++; $display("FAIL reset_lo: got %h want 0", LO); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_multu;
    int lat, bn;
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bn);
    total++; if (lat !== 34) begin bad++; $display("FAIL multu_latency: got %0d want 34", lat); end
    total++; if (bn !== 33) begin bad++; $display("FAIL multu_busy_cycles: got %0d want 33", bn); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL multu_busy_at_done: got %b want 0", busy); end
    total++; if (HI !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi: got %h want fffffffe", HI); end
    total++; if (LO !== 32'h0000_0001) begin bad++; $display("FAIL multu_lo: got %h want 00000001", LO); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL multu_done_pulse: got %b want 0", done); end
    do_op(2'b00, 32'h1234_5678, 32'h0000_0010, lat, bn);
    total++; if (HI !== 32'h0000_0001) begin bad++; $display("FAIL multu2_hi: got %h want 00000001", HI); end
    total++; if (LO !== 32'h2345_6780) begin bad++; $display("FAIL multu2_lo: got %h want 23456780", LO); end
  endtask

  task automatic test_divu;
    int lat, bn;
    do_op(2'b10, 32'd100, 32'd7, lat, bn);
    total++; if (lat !== 34) begin bad++; $display("FAIL divu_latency: got %0d want 34", lat); end
    total++; if (LO !== 32'd14) begin bad++; $display("FAIL divu_lo: got %0d want 14", LO); end
    total++; if (HI !== 32'd2) begin bad++; $display("FAIL divu_hi: got %0d want 2", HI); end
    do_op(2'b10, 32'd5, 32'd0, lat, bn);
    total++; if (LO !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divu_by0_lo: got %h want ffffffff", LO); end
    total++; if (HI !== 32'd5) begin bad++; $display("FAIL divu_by0_hi: got %h want 00000005", HI); end
    do_op(2'b10, 32'hFFFF_FFFF, 32'd1, lat, bn);
    total++; if (LO !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divu_by1_lo: got %h want ffffffff", LO); end
    total++; if (HI !== 32'd0) begin bad++; $display("FAIL divu_by1_hi: got %h want 0", HI); end
  endtask

`ifdef MULDIV_SIGNED_EN
  task automatic test_signed;
    int lat, bn;
    do_op(2'b01, 32'hFFFF_FFFD, 32'd5, lat, bn);
    total++; if (HI !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi: got %h want ffffffff", HI); end
    total++; if (LO !== 32'hFFFF_FFF1) begin bad++; $display("FAIL mult_lo: got %h want fffffff1", LO); end
    do_op(2'b11, 32'hFFFF_FFF9, 32'd2, lat, bn);
    total++; if (LO !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo: got %h want fffffffd", LO); end
    total++; if (HI !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi: got %h want ffffffff", HI); end
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, lat, bn);
    total++; if (LO !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf_lo: got %h want 80000000", LO); end
    total++; if (HI !== 32'd0) begin bad++; $display("FAIL div_ovf_hi: got %h want 0", HI); end
    total++; if (lat !== 34) begin bad++; $display("FAIL div_ovf_latency: got %0d want 34", lat); end
    do_op(2'b11, 32'hFFFF_FFFB, 32'd0, lat, bn);
    total++; if (LO !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_by0_lo: got %h want ffffffff", LO); end
    total++; if (HI !== 32'hFFFF_FFFB) begin bad++; $display("FAIL div_by0_hi: got %h want fffffffb", HI); end
  endtask
`else
  task automatic test_signed;
    int lat, bn;
    do_op(2'b01, 32'hFFFF_FFFD, 32'd5, lat, bn);
    total++; if (HI !== 32'h0000_0004) begin bad++; $display("FAIL mult_unsigned_hi: got %h want 00000004", HI); end
    total++; if (LO !== 32'hFFFF_FFF1) begin bad++; $display("FAIL mult_unsigned_lo: got %h want fffffff1", LO); end
    do_op(2'b11, 32'hFFFF_FFF9, 32'd2, lat, bn);
    total++; if (LO !== 32'h7FFF_FFFC) begin bad++; $display("FAIL div_unsigned_lo: got %h want 7ffffffc", LO); end
    total++; if (HI !== 32'd1) begin bad++; $display("FAIL div_unsigned_hi: got %h want 1", HI); end
  endtask
`endif

  task automatic test_back_to_back;
    int pulses;
    pulses = 0;
    @(negedge clk);
    start = 1'b1; op = 2'b00; Adat = 32'd6; Bdat = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k < 45; k++) begin
      if (k == 5) begin
        start = 1'b1; op = 2'b10; hi_we = 1'b1; Wdat = 32'h0000_DEAD;
        Adat = 32'd100; Bdat = 32'd7;
      end else begin
        start = 1'b0; hi_we = 1'b0;
      end
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL b2b_done_pulses: got %0d want 1", pulses); end
    total++; if (HI !== 32'd0) begin bad++; $display("FAIL b2b_hi: got %h want 0", HI); end
    total++; if (LO !== 32'd42) begin bad++; $display("FAIL b2b_lo: got %0d want 42", LO); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle: got %b want 0", busy); end
  endtask

  task automatic test_mthi_mtlo;
    int lat, bn;
    @(negedge clk); hi_we = 1'b1; Wdat = 32'h0000_1234;
    @(posedge clk); #1; hi_we = 1'b0;
    total++; if (HI !== 32'h0000_1234) begin bad++; $display("FAIL mthi: got %h want 00001234", HI); end
    @(negedge clk); lo_we = 1'b1; Wdat = 32'h0000_5678;
    @(posedge clk); #1; lo_we = 1'b0;
    total++; if (LO !== 32'h0000_5678) begin bad++; $display("FAIL mtlo: got %h want 00005678", LO); end
    total++; if (HI !== 32'h0000_1234) begin bad++; $display("FAIL mtlo_hi_hold: got %h want 00001234", HI); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL mt_no_done: got %b want 0", done); end
    @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; Wdat = 32'hAAAA_5555;
    @(posedge clk); #1; hi_we = 1'b0; lo_we = 1'b0;
    total++; if (HI !== 32'hAAAA_5555) begin bad++; $display("FAIL mt_both_hi: got %h want aaaa5555", HI); end
    total++; if (LO !== 32'hAAAA_5555) begin bad++; $display("FAIL mt_both_lo: got %h want aaaa5555", LO); end
    hi_we = 1'b1; Wdat = 32'h0000_BEEF;
    do_op(2'b00, 32'd2, 32'd3, lat, bn);
    total++; if (HI !== 32'd0) begin bad++; $display("FAIL start_wins_hi: got %h want 0", HI); end
    total++; if (LO !== 32'd6) begin bad++; $display("FAIL start_wins_lo: got %h want 6", LO); end
  endtask

  task automatic test_reset_abort;
    int lat, bn, late_done;
    @(negedge clk); hi_we = 1'b1; Wdat = 32'h0000_0055;
    @(negedge clk); hi_we = 1'b0;
    start = 1'b1; op = 2'b10; Adat = 32'd100; Bdat = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done: got %b want 0", done); end
    total++; if (HI !== '0) begin bad++; $display("FAIL abort_hi: got %h want 0", HI); end
    total++; if (LO !== '0) begin bad++; $display("FAIL abort_lo: got %h want 0", LO); end
    late_done = 0;
    repeat (30) begin @(posedge clk); #1; if (done === 1'b1) late_done++; end
    total++; if (late_done !== 0) begin bad++; $display("FAIL abort_no_done: got %0d pulses want 0", late_done); end
    do_op(2'b10, 32'd1000, 32'd10, lat, bn);
    total++; if (lat !== 34) begin bad++; $display("FAIL post_abort_latency: got %0d want 34", lat); end
    total++; if (LO !== 32'd100) begin bad++; $display("FAIL post_abort_lo: got %0d want 100", LO); end
    total++; if (HI !== 32'd0) begin bad++; $display("FAIL post_abort_hi: got %0d want 0", HI); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_divu();
    test_signed();
    test_back_to_back();
    test_mthi_mtlo();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
